lsb_mem_responder: RTL and testbench
====================================

Name: lsb_mem_responder

Overview:
- Responder end of the load/store buffer's cache request interface (valid/wr/size/addr/value in; ready/res out).
- Services one request at a time.
- Serialises each byte, halfword or word access into single-byte transactions on the byte-wide synchronous RAM/IO bus.
- Assembles and extends load data; returns `cache_ready` as a one-cycle pulse.

Parameters:
- ADDR_WIDTH, 32, width of request address and `mem_a`.
- IO_HI, 2'b11, value of `addr[17:16]` that marks the IO region (write stalls on `io_buffer_full`).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-high
- rdy_in  input  1  global enable; low freezes all state
- cache_valid  input  1  request present; held until `cache_ready` pulse
- cache_wr  input  1  1 = store, 0 = load
- cache_size  input  3  [1:0] 0 byte / 1 half / 2 word; [2] 1 = zero-extend, 0 = sign-extend (loads only)
- cache_addr  input  32  byte address
- cache_value  input  32  store data, little-endian
- cache_ready  output  1  one-cycle completion pulse
- cache_res  output  32  load result, valid while `cache_ready` = 1
- mem_din  input  8  RAM read byte (data for address presented previous cycle)
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write this cycle
- io_buffer_full  input  1  IO output buffer full

Behaviour:
- Reset (asynchronous, any state, mid-transaction included):
  - state = IDLE, byte counter = 0, all latched fields = 0.
  - `cache_ready` = 0, `cache_res` = 0, `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0.
  - Any partially written store is abandoned.
- `rdy_in` = 0: no register changes; `mem_wr` forced 0; `cache_ready` forced 0.
- States: IDLE, READ, WRITE, DONE.
- Byte count: n = 1/2/4 for `size[1:0]` = 0/1/2; `size[1:0]` = 3 treated as word.
- IDLE:
  - `cache_valid` = 1 latches wr/size/addr/value (cycle 0).
  - Next state is READ or WRITE; counter = 0.
- READ:
  - In cycle k (1..n): `mem_a` = addr + (k-1), `mem_wr` = 0.
  - `mem_din` sampled in cycles 2..n+1 as byte k-2.
  - After the last byte is captured: extend, register into `cache_res`, go to DONE.
  - `cache_ready` is high in cycle n+2: byte 3, word 6.
- WRITE:
  - In cycle k: `mem_a` = addr + (k-1), `mem_dout` = value[8(k-1)+7 : 8(k-1)], `mem_wr` = 1.
  - After byte n-1: go to DONE, `cache_ready` high in cycle n+1.
  - IO stall: while `addr[17:16]` == IO_HI and `io_buffer_full` = 1, WRITE holds the current byte with `mem_wr` = 0 and retries each cycle; the counter does not advance.
  - Reads are never stalled.
- DONE:
  - `cache_ready` = 1 for exactly one cycle; `cache_res` valid (0 for stores).
  - `cache_valid` is ignored in DONE (it still reflects the completed request).
  - Next state IDLE. A request whose fields were updated on the DONE edge is accepted in the following IDLE cycle.
- Address arithmetic: 32-bit wrap; no alignment check. A misaligned request accesses consecutive bytes.
- Extension:
  - byte: [7] replicated to bits 31:8 when `size[2]` = 0, else zeros.
  - halfword: same rule on bit [15].
  - word: unchanged.
- `mem_a` / `mem_dout` hold their last value in IDLE/DONE; `mem_wr` = 0 outside active WRITE beats.
- Throughput: back-to-back requests cost one IDLE cycle between DONE and the next cycle 1.

Test Plan:
- LW: addr 0x100, RAM[0x100..0x103] = 11 22 33 44 → `mem_a` 0x100..0x103 on cycles 1..4, `cache_ready` pulse in cycle 6, `cache_res` = 0x44332211.
- LB / LBU: RAM[0x7] = 0x80 → LB (size 0) returns 0xFFFFFF80 in cycle 3; LBU (size 4) returns 0x00000080.
- SH: value 0xDEADBEEF, addr 0x202 → writes EF@0x202, BE@0x203 with `mem_wr` = 1; `cache_ready` in cycle 3; RAM[0x204] untouched.
- IO stall: SB addr 0x30000, `io_buffer_full` = 1 for 5 cycles → `mem_wr` stays 0; byte written the cycle after deassert; `cache_ready` exactly once.
- Back-to-back: LW then SW presented on the `cache_ready` edge → second request starts after one IDLE cycle, no duplicated or dropped access; `rdy_in` low 3 cycles mid-LW → same result, latency +3.
- Reset mid-word-write after 2 bytes → all outputs 0 immediately, IDLE; next LH completes normally.

Source files
------------

// File: rtl/lsb_mem_responder.sv
// lsb_mem_responder
// -----------------------------------------------------------------------------
// Responder end of the load/store buffer's cache request interface. It accepts
// one request at a time and turns each byte, halfword or word access into a
// sequence of single-byte transactions on a byte-wide synchronous RAM/IO bus.
// Load bytes are reassembled (little-endian), sign- or zero-extended, and
// returned with a one-cycle cache_ready pulse.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   rdy_in                global enable; low freezes every register
//   cache_valid           request present, held until cache_ready
//   cache_wr              1 = store, 0 = load
//   cache_size[2:0]       [1:0] 0 byte / 1 half / 2,3 word; [2] 1 = zero-extend
//   cache_addr            byte address of the first byte
//   cache_value           store data, little-endian
//   cache_ready           one-cycle completion pulse
//   cache_res             load result (0 for stores), valid with cache_ready
//   mem_din               RAM read byte for the address presented last cycle
//   mem_dout, mem_a       RAM write byte / byte address
//   mem_wr                write strobe
//   io_buffer_full        IO output buffer full; stalls IO-region stores
// -----------------------------------------------------------------------------
module lsb_mem_responder #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_HI      = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  cache_valid,
    input  logic                  cache_wr,
    input  logic [2:0]            cache_size,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic [31:0]           cache_value,
    output logic                  cache_ready,
    output logic [31:0]           cache_res,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [2:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           value_q, value_d;
    logic [31:0]           rd_q, rd_d;
    logic [31:0]           res_q, res_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;

    logic [2:0]  nbytes;
    logic [2:0]  cnt_inc;
    logic [1:0]  rd_idx;
    logic [31:0] rd_asm;
    logic [31:0] rd_ext;
    logic        io_stall;

    always_comb begin
        case (size_q[1:0])
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign cnt_inc  = cnt_q + 3'd1;
    assign io_stall = (state_q == WRITE) && (addr_q[17:16] == IO_HI) && io_buffer_full;

    // In READ, the cycle with counter c (c >= 1) receives byte c-1 on mem_din.
    // rd_asm is the buffer with that byte merged in, so the final byte can be
    // extended and registered on the same edge it arrives.
    always_comb begin
        rd_idx = 2'(cnt_q - 3'd1);
        rd_asm = rd_q;
        if (cnt_q != 3'd0)
            rd_asm[{rd_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        case (size_q[1:0])
            2'd0:    rd_ext = {{24{~size_q[2] & rd_asm[7]}},  rd_asm[7:0]};
            2'd1:    rd_ext = {{16{~size_q[2] & rd_asm[15]}}, rd_asm[15:0]};
            default: rd_ext = rd_asm;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        size_d     = size_q;
        addr_d     = addr_q;
        value_d    = value_q;
        rd_d       = rd_q;
        res_d      = res_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        case (state_q)
            IDLE: begin
                if (cache_valid) begin
                    wr_d    = cache_wr;
                    size_d  = cache_size;
                    addr_d  = cache_addr;
                    value_d = cache_value;
                    cnt_d   = 3'd0;
                    rd_d    = 32'd0;
                    res_d   = 32'd0;
                    mem_a_d = cache_addr;
                    if (cache_wr) begin
                        mem_dout_d = cache_value[7:0];
                        state_d    = WRITE;
                    end else begin
                        state_d    = READ;
                    end
                end
            end
            READ: begin
                if (cnt_q != 3'd0)
                    rd_d = rd_asm;
                if (cnt_q == nbytes) begin
                    res_d   = rd_ext;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                    // Past the last byte the address just holds.
                    if (cnt_inc < nbytes)
                        mem_a_d = addr_q + ADDR_WIDTH'(cnt_inc);
                end
            end
            WRITE: begin
                if (!io_stall) begin
                    if (cnt_inc == nbytes) begin
                        state_d = DONE;
                    end else begin
                        cnt_d      = cnt_inc;
                        mem_a_d    = addr_q + ADDR_WIDTH'(cnt_inc);
                        mem_dout_d = value_q[{cnt_inc[1:0], 3'b000} +: 8];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            wr_q       <= 1'b0;
            size_q     <= 3'd0;
            addr_q     <= '0;
            value_q    <= 32'd0;
            rd_q       <= 32'd0;
            res_q      <= 32'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            value_q    <= value_d;
            rd_q       <= rd_d;
            res_q      <= res_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
        end
    end

    // While frozen mid-read, present the address of the byte the next enabled
    // cycle expects, so the synchronous RAM returns the right data on resume
    // even though the read pipeline registers are held.
    always_comb begin
        mem_a = mem_a_q;
        if (!rdy_in && state_q == READ && cnt_q != 3'd0)
            mem_a = addr_q + ADDR_WIDTH'(cnt_q) - ADDR_WIDTH'(1);
    end

    assign mem_dout    = mem_dout_q;
    assign mem_wr      = rdy_in && (state_q == WRITE) && !io_stall;
    assign cache_ready = rdy_in && (state_q == DONE);
    assign cache_res   = res_q;

endmodule

// File: tb/tb_lsb_mem_responder.sv
// Testbench for lsb_mem_responder: a 4 KiB synchronous RAM model on the byte
// bus, directed scenarios and randomized requests checked against a byte-level
// memory model kept in the bench.
module tb_lsb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        valid = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  size = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] value = 32'd0;
    logic        iof = 1'b0;
    logic        ready;
    logic [31:0] res;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [31:0] ma;
    logic        mwr;

    always #5 clk = ~clk;

    lsb_mem_responder #(.ADDR_WIDTH(32), .IO_HI(2'b11)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .cache_valid(valid), .cache_wr(wr), .cache_size(size),
        .cache_addr(addr), .cache_value(value),
        .cache_ready(ready), .cache_res(res),
        .mem_din(din), .mem_dout(dout), .mem_a(ma), .mem_wr(mwr),
        .io_buffer_full(iof)
    );

    // Bus-side RAM (low 12 address bits) with a backdoor for preloading.
    logic [7:0]  ram [0:4095];
    logic [7:0]  model_mem [0:4095];
    logic        fill = 1'b0;
    logic        pk_en = 1'b0;
    logic [11:0] pk_a = 12'd0;
    logic [7:0]  pk_d = 8'd0;
    logic [31:0] wlog_a [$];
    logic [7:0]  wlog_d [$];
    logic [31:0] atrace [$];
    int          rdy_pulses = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 37 + 5);
        end else if (pk_en) begin
            ram[pk_a] <= pk_d;
        end else if (mwr) begin
            ram[ma[11:0]] <= dout;
            wlog_a.push_back(ma);
            wlog_d.push_back(dout);
        end
        din <= ram[ma[11:0]];
    end

    always @(negedge clk) if (ready) rdy_pulses <= rdy_pulses + 1;

    function automatic int nb(input logic [2:0] sz);
        case (sz[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] sz, input logic [31:0] a);
        logic [31:0] r = 32'd0;
        int n = nb(sz);
        for (int i = 0; i < n; i++) r[8*i +: 8] = model_mem[12'(a + 32'(i))];
        if (!sz[2] && n < 4 && r[8*n-1])
            for (int j = 8*n; j < 32; j++) r[j] = 1'b1;
        return r;
    endfunction

    task automatic model_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] v);
        for (int i = 0; i < nb(sz); i++) model_mem[12'(a + 32'(i))] = v[8*i +: 8];
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pk_a = a[11:0]; pk_d = d; pk_en = 1'b1;
        model_mem[a[11:0]] = d;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    // Drives one request from the current (IDLE or DONE) cycle and waits for
    // cache_ready. lat = cycles from this call to the ready cycle, -1 on timeout.
    task automatic do_req(input bit w, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] v, input int stall, input int frz_at,
                          input int frz_len, input bit keep,
                          output logic [31:0] r, output int lat);
        int cyc = 0;
        wr = w; size = sz; addr = a; value = v; valid = 1'b1;
        iof = (stall > 0);
        atrace.delete();
        lat = -1; r = 32'hxxxxxxxx;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            iof = (cyc <= stall);
            rdy = !(frz_len > 0 && cyc >= frz_at && cyc < frz_at + frz_len);
            #1;
            atrace.push_back(ma);
            if (ready) begin r = res; lat = cyc; break; end
        end
        rdy = 1'b1; iof = 1'b0;
        if (!keep) begin valid = 1'b0; @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        #2;
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_tests++; if (res !== 32'd0) begin n_fail++; $display("FAIL reset_res got %h want 0", res); end
        n_tests++; if (ma !== 32'd0) begin n_fail++; $display("FAIL reset_mem_a got %h want 0", ma); end
        n_tests++; if (dout !== 8'd0) begin n_fail++; $display("FAIL reset_mem_dout got %h want 0", dout); end
        n_tests++; if (mwr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr got %b want 0", mwr); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw;
        logic [31:0] r; int lat; int base;
        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        base = wlog_a.size();
        do_req(1'b0, 3'd2, 32'h100, 32'd0, 0, 0, 0, 1'b0, r, lat);
        n_tests++; if (r !== 32'h44332211) begin n_fail++; $display("FAIL lw_res got %h want 44332211", r); end
        n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL lw_latency got %0d want 6", lat); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (atrace.size() <= i || atrace[i] !== 32'h100 + 32'(i)) begin
                n_fail++; $display("FAIL lw_mem_a cycle %0d got %h want %h", i + 1,
                                   (atrace.size() > i) ? atrace[i] : 32'hx, 32'h100 + 32'(i));
            end
        end
        n_tests++; if (wlog_a.size() !== base) begin n_fail++; $display("FAIL lw_no_writes got %0d want %0d", wlog_a.size(), base); end
    endtask

    task automatic test_lb_lbu;
        logic [31:0] r; int lat;
        poke(32'h7, 8'h80); poke(32'h8, 8'hC3);
        do_req(1'b0, 3'd0, 32'h7, 32'd0, 0, 0, 0, 1'b0, r, lat);
        n_tests++; if (r !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_res got %h want ffffff80", r); end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL lb_latency got %0d want 3", lat); end
        do_req(1'b0, 3'd4, 32'h7, 32'd0, 0, 0, 0, 1'b0, r, lat);
        n_tests++; if (r !== 32'h00000080) begin n_fail++; $display("FAIL lbu_res got %h want 00000080", r); end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL lbu_latency got %0d want 3", lat); end
        do_req(1'b0, 3'd1, 32'h7, 32'd0, 0, 0, 0, 1'b0, r, lat);
        n_tests++; if (r !== 32'hFFFFC380) begin n_fail++; $display("FAIL lh_misaligned got %h want ffffc380", r); end
        do_req(1'b0, 3'd5, 32'h7, 32'd0, 0, 0, 0, 1'b0, r, lat);
        n_tests++; if (r !== 32'h0000C380) begin n_fail++; $display("FAIL lhu_misaligned got %h want 0000c380", r); end
    endtask

    task automatic test_sh;
        logic [31:0] r; int lat; int base;
        poke(32'h204, 8'h5A);
        base = wlog_a.size();
        do_req(1'b1, 3'd1, 32'h202, 32'hDEADBEEF, 0, 0, 0, 1'b0, r, lat);
        model_store(3'd1, 32'h202, 32'hDEADBEEF);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL sh_latency got %0d want 3", lat); end
        n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL sh_res got %h want 0", r); end
        n_tests++;
        if (wlog_a.size() !== base + 2) begin
            n_fail++; $display("FAIL sh_write_count got %0d want 2", wlog_a.size() - base);
        end else if (wlog_a[base] !== 32'h202 || wlog_d[base] !== 8'hEF ||
                     wlog_a[base+1] !== 32'h203 || wlog_d[base+1] !== 8'hBE) begin
            n_fail++; $display("FAIL sh_writes got %h:%h %h:%h want 202:ef 203:be",
                               wlog_a[base], wlog_d[base], wlog_a[base+1], wlog_d[base+1]);
        end
        do_req(1'b0, 3'd4, 32'h204, 32'd0, 0, 0, 0, 1'b0, r, lat);
        n_tests++; if (r !== 32'h5A) begin n_fail++; $display("FAIL sh_neighbour got %h want 5a", r); end
    endtask

    task automatic test_io_stall;
        logic [31:0] r; int lat; int base; int p0;
        base = wlog_a.size(); p0 = rdy_pulses;
        do_req(1'b1, 3'd0, 32'h30000, 32'h000000A5, 5, 0, 0, 1'b0, r, lat);
        model_store(3'd0, 32'h30000, 32'h000000A5);
        @(posedge clk); #1;
        n_tests++; if (lat !== 7) begin n_fail++; $display("FAIL io_latency got %0d want 7", lat); end
        n_tests++;
        if (wlog_a.size() !== base + 1) begin
            n_fail++; $display("FAIL io_write_count got %0d want 1", wlog_a.size() - base);
        end else if (wlog_a[base] !== 32'h30000 || wlog_d[base] !== 8'hA5) begin
            n_fail++; $display("FAIL io_write got %h:%h want 30000:a5", wlog_a[base], wlog_d[base]);
        end
        n_tests++; if (rdy_pulses - p0 !== 1) begin n_fail++; $display("FAIL io_ready_pulses got %0d want 1", rdy_pulses - p0); end
        // Loads from the IO region ignore io_buffer_full.
        do_req(1'b0, 3'd4, 32'h30000, 32'd0, 4, 0, 0, 1'b0, r, lat);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL io_read_latency got %0d want 3", lat); end
        n_tests++; if (r !== 32'hA5) begin n_fail++; $display("FAIL io_read_res got %h want a5", r); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r; int lat; int base; logic [31:0] v; logic [31:0] e;
        for (int i = 0; i < 4; i++) poke(32'h40 + 32'(i), 8'($urandom));
        e = exp_load(3'd2, 32'h40);
        v = $urandom;
        do_req(1'b0, 3'd2, 32'h40, 32'd0, 0, 0, 0, 1'b1, r, lat);
        n_tests++; if (r !== e) begin n_fail++; $display("FAIL b2b_lw_res got %h want %h", r, e); end
        base = wlog_a.size();
        do_req(1'b1, 3'd2, 32'h48, v, 0, 0, 0, 1'b0, r, lat);
        model_store(3'd2, 32'h48, v);
        n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL b2b_sw_latency got %0d want 6", lat); end
        n_tests++;
        if (wlog_a.size() !== base + 4) begin
            n_fail++; $display("FAIL b2b_sw_count got %0d want 4", wlog_a.size() - base);
        end else begin
            for (int i = 0; i < 4; i++)
                if (wlog_a[base+i] !== 32'h48 + 32'(i) || wlog_d[base+i] !== v[8*i +: 8]) begin
                    n_fail++; $display("FAIL b2b_sw_byte %0d got %h:%h want %h:%h", i,
                                       wlog_a[base+i], wlog_d[base+i], 32'h48 + 32'(i), v[8*i +: 8]);
                    break;
                end
        end
        do_req(1'b0, 3'd2, 32'h40, 32'd0, 0, 2, 3, 1'b0, r, lat);
        n_tests++; if (r !== e) begin n_fail++; $display("FAIL frz_lw_res got %h want %h", r, e); end
        n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL frz_lw_latency got %0d want 9", lat); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r; int lat; int base;
        base = wlog_a.size();
        wr = 1'b1; size = 3'd2; addr = 32'h300; value = 32'h01020304; valid = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got %b want 0", ready); end
        n_tests++; if (ma !== 32'd0) begin n_fail++; $display("FAIL rstmid_mem_a got %h want 0", ma); end
        n_tests++; if (dout !== 8'd0) begin n_fail++; $display("FAIL rstmid_mem_dout got %h want 0", dout); end
        n_tests++; if (mwr !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_wr got %b want 0", mwr); end
        n_tests++; if (wlog_a.size() !== base + 2) begin n_fail++; $display("FAIL rstmid_bytes got %0d want 2", wlog_a.size() - base); end
        valid = 1'b0;
        model_store(3'd1, 32'h300, 32'h00000304);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        do_req(1'b0, 3'd1, 32'h300, 32'd0, 0, 0, 0, 1'b0, r, lat);
        n_tests++; if (r !== 32'h00000304) begin n_fail++; $display("FAIL rstmid_lh got %h want 00000304", r); end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL rstmid_lh_latency got %0d want 4", lat); end
    endtask

    task automatic test_wrap;
        logic [31:0] r; int lat; logic [31:0] e; int base;
        e = exp_load(3'd2, 32'hFFFFFFFF);
        do_req(1'b0, 3'd2, 32'hFFFFFFFF, 32'd0, 0, 0, 0, 1'b0, r, lat);
        n_tests++; if (r !== e) begin n_fail++; $display("FAIL wrap_lw_res got %h want %h", r, e); end
        n_tests++;
        if (atrace.size() < 4 || atrace[0] !== 32'hFFFFFFFF || atrace[1] !== 32'h0 ||
            atrace[2] !== 32'h1 || atrace[3] !== 32'h2) begin
            n_fail++; $display("FAIL wrap_mem_a got %h %h want ffffffff 00000000",
                               (atrace.size() > 0) ? atrace[0] : 32'hx, (atrace.size() > 1) ? atrace[1] : 32'hx);
        end
        base = wlog_a.size();
        do_req(1'b1, 3'd1, 32'hFFFFFFFF, 32'h0000C0DE, 0, 0, 0, 1'b0, r, lat);
        model_store(3'd1, 32'hFFFFFFFF, 32'h0000C0DE);
        n_tests++;
        if (wlog_a.size() !== base + 2 || wlog_a[base] !== 32'hFFFFFFFF || wlog_a[base+1] !== 32'h0 ||
            wlog_d[base] !== 8'hDE || wlog_d[base+1] !== 8'hC0) begin
            n_fail++; $display("FAIL wrap_sh count %0d want 2 bytes de@ffffffff c0@0", wlog_a.size() - base);
        end
    endtask

    task automatic test_random;
        logic [31:0] r, a, v, e;
        logic [2:0]  sz;
        bit          w;
        int          lat, elat, stall, frz_at, frz_len, base, n;
        for (int it = 0; it < 40; it++) begin
            w = 1'($urandom); sz = 3'($urandom); a = $urandom; v = $urandom;
            if ($urandom_range(0, 3) == 0) a[17:16] = 2'b11;
            frz_len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            frz_at  = $urandom_range(1, 2);
            stall   = (frz_len == 0) ? $urandom_range(0, 3) : 0;
            n       = nb(sz);
            elat    = n + (w ? 1 : 2) + frz_len + ((w && a[17:16] == 2'b11) ? stall : 0);
            e       = w ? 32'd0 : exp_load(sz, a);
            base    = wlog_a.size();
            do_req(w, sz, a, v, stall, frz_at, frz_len, 1'b0, r, lat);
            n_tests++; if (lat !== elat) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", it, lat, elat); end
            n_tests++; if (r !== e) begin n_fail++; $display("FAIL rnd%0d_res got %h want %h", it, r, e); end
            n_tests++;
            if (wlog_a.size() !== base + (w ? n : 0)) begin
                n_fail++; $display("FAIL rnd%0d_write_count got %0d want %0d", it, wlog_a.size() - base, w ? n : 0);
            end else if (w) begin
                for (int i = 0; i < n; i++)
                    if (wlog_a[base+i] !== a + 32'(i) || wlog_d[base+i] !== v[8*i +: 8]) begin
                        n_fail++; $display("FAIL rnd%0d_write_byte %0d got %h:%h want %h:%h", it, i,
                                           wlog_a[base+i], wlog_d[base+i], a + 32'(i), v[8*i +: 8]);
                        break;
                    end
            end
            if (w) model_store(sz, a, v);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model_mem[i] = 8'(i * 37 + 5);
        fill = 1'b1;
        @(posedge clk); #1;
        fill = 1'b0;
        test_reset;
        test_lw;
        test_lb_lbu;
        test_sh;
        test_io_stall;
        test_back_to_back;
        test_reset_mid;
        test_wrap;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
